// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the writeback stage and register file.
package wb_regfile_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LINK_REG  = 31;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_core.sv
// Register storage with synchronous clear, one write port and two raw read ports.
module regfile_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned IDX_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr1,
  input  logic [IDX_W-1:0]  i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [NREGS];

  // Entry 0 is cleared on reset and never written, so it always reads zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, destination resolution, commit into the
// register file with write-through bypass on both read ports, commit counter.
module wb_regfile #(
  parameter int unsigned DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned LINK_REG = wb_regfile_pkg::LINK_REG,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                                 Clk_in,
  input  logic                                 Rst,
  input  logic                                 RegWrite_in,
  input  logic                                 MemtoReg_in,
  input  logic [DATA_W-1:0]                    ALUResult_in,
  input  logic [DATA_W-1:0]                    ReadData_in,
  input  logic [wb_regfile_pkg::REG_IDX_W-1:0] WriteReg_in,
  input  logic                                 JR_in,
  input  logic                                 Jal_in,
  input  logic [wb_regfile_pkg::REG_IDX_W-1:0] ReadReg1_in,
  input  logic [wb_regfile_pkg::REG_IDX_W-1:0] ReadReg2_in,
  output logic [DATA_W-1:0]                    ReadData1_out,
  output logic [DATA_W-1:0]                    ReadData2_out,
  output logic [DATA_W-1:0]                    WriteData_out,
  output logic                                 WriteEn_out,
  output logic [wb_regfile_pkg::REG_IDX_W-1:0] WriteAddr_out,
  output logic [CNT_W-1:0]                     CommitCount_out
);

  import wb_regfile_pkg::*;

  logic [DATA_W-1:0]    w_wdata;
  logic [REG_IDX_W-1:0] w_waddr;
  logic                 w_we;
  logic [DATA_W-1:0]    w_raw1;
  logic [DATA_W-1:0]    w_raw2;
  logic [CNT_W-1:0]     r_count;

  assign w_wdata = Jal_in ? ALUResult_in : (MemtoReg_in ? ReadData_in : ALUResult_in);
  assign w_waddr = Jal_in ? REG_IDX_W'(LINK_REG) : WriteReg_in;
  // Rst gates the enable so neither bypass nor commit happen during reset.
  assign w_we    = RegWrite_in & ~JR_in & ~Rst & (w_waddr != ZERO_REG);

  regfile_core #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (REG_IDX_W)
  ) u_core (
    .i_clk    (Clk_in),
    .i_rst    (Rst),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr1 (ReadReg1_in),
    .i_raddr2 (ReadReg2_in),
    .o_rdata1 (w_raw1),
    .o_rdata2 (w_raw2)
  );

  always_comb begin
    ReadData1_out = w_raw1;
    if (ReadReg1_in == ZERO_REG) begin
      ReadData1_out = '0;
    end else if (w_we && (ReadReg1_in == w_waddr)) begin
      ReadData1_out = w_wdata;
    end
  end

  always_comb begin
    ReadData2_out = w_raw2;
    if (ReadReg2_in == ZERO_REG) begin
      ReadData2_out = '0;
    end else if (w_we && (ReadReg2_in == w_waddr)) begin
      ReadData2_out = w_wdata;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      r_count <= '0;
    end else if (w_we) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign WriteData_out   = w_wdata;
  assign WriteEn_out     = w_we;
  assign WriteAddr_out   = w_waddr;
  assign CommitCount_out = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile with hand-computed expectations.
module tb_wb_regfile;

  logic        Clk_in;
  logic        Rst;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic [31:0] ALUResult_in;
  logic [31:0] ReadData_in;
  logic [4:0]  WriteReg_in;
  logic        JR_in;
  logic        Jal_in;
  logic [4:0]  ReadReg1_in;
  logic [4:0]  ReadReg2_in;
  logic [31:0] ReadData1_out;
  logic [31:0] ReadData2_out;
  logic [31:0] WriteData_out;
  logic        WriteEn_out;
  logic [4:0]  WriteAddr_out;
  logic [31:0] CommitCount_out;

  int n_checks;
  int n_fail;

  wb_regfile dut (
    .Clk_in          (Clk_in),
    .Rst             (Rst),
    .RegWrite_in     (RegWrite_in),
    .MemtoReg_in     (MemtoReg_in),
    .ALUResult_in    (ALUResult_in),
    .ReadData_in     (ReadData_in),
    .WriteReg_in     (WriteReg_in),
    .JR_in           (JR_in),
    .Jal_in          (Jal_in),
    .ReadReg1_in     (ReadReg1_in),
    .ReadReg2_in     (ReadReg2_in),
    .ReadData1_out   (ReadData1_out),
    .ReadData2_out   (ReadData2_out),
    .WriteData_out   (WriteData_out),
    .WriteEn_out     (WriteEn_out),
    .WriteAddr_out   (WriteAddr_out),
    .CommitCount_out (CommitCount_out)
  );

  initial Clk_in = 1'b0;
  always #5 Clk_in = ~Clk_in;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RegWrite_in  = 1'b0;
    MemtoReg_in  = 1'b0;
    ALUResult_in = '0;
    ReadData_in  = '0;
    WriteReg_in  = '0;
    JR_in        = 1'b0;
    Jal_in       = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk_in);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    Rst         = 1'b1;
    ReadReg1_in = '0;
    ReadReg2_in = '0;
    idle();
    step();
    step();
    Rst = 1'b0;
    #1;

    // 1: all registers clear after reset
    for (int i = 0; i < 32; i++) begin
      ReadReg1_in = 5'(i);
      ReadReg2_in = 5'(31 - i);
      #1;
      chk_eq($sformatf("rst_rd1_r%0d", i), ReadData1_out, 32'h0);
      chk_eq($sformatf("rst_rd2_r%0d", 31 - i), ReadData2_out, 32'h0);
    end
    chk_eq("rst_count", CommitCount_out, 32'd0);

    // 2: ALU write with same-cycle bypass
    RegWrite_in  = 1'b1;
    ALUResult_in = 32'hDEADBEEF;
    ReadData_in  = 32'h0BADF00D;
    WriteReg_in  = 5'd8;
    ReadReg1_in  = 5'd8;
    ReadReg2_in  = 5'd9;
    #1;
    chk_eq("alu_we", 32'(WriteEn_out), 32'd1);
    chk_eq("alu_waddr", 32'(WriteAddr_out), 32'd8);
    chk_eq("alu_wdata", WriteData_out, 32'hDEADBEEF);
    chk_eq("alu_bypass1", ReadData1_out, 32'hDEADBEEF);
    chk_eq("alu_nobypass2", ReadData2_out, 32'h0);
    step();
    idle();
    ReadReg2_in = 5'd8;
    #1;
    chk_eq("alu_stored", ReadData2_out, 32'hDEADBEEF);
    chk_eq("alu_count", CommitCount_out, 32'd1);

    // 3a: load result selected by MemtoReg
    RegWrite_in  = 1'b1;
    MemtoReg_in  = 1'b1;
    ReadData_in  = 32'h12345678;
    ALUResult_in = 32'h0;
    WriteReg_in  = 5'd9;
    #1;
    chk_eq("ld_wdata", WriteData_out, 32'h12345678);
    step();
    idle();
    ReadReg1_in = 5'd9;
    #1;
    chk_eq("ld_stored", ReadData1_out, 32'h12345678);
    chk_eq("ld_count", CommitCount_out, 32'd2);

    // 3b: writes to register 0 are ignored
    RegWrite_in  = 1'b1;
    ALUResult_in = 32'hFFFFFFFF;
    WriteReg_in  = 5'd0;
    ReadReg1_in  = 5'd0;
    #1;
    chk_eq("r0_we", 32'(WriteEn_out), 32'd0);
    chk_eq("r0_bypass", ReadData1_out, 32'h0);
    step();
    idle();
    #1;
    chk_eq("r0_stored", ReadData1_out, 32'h0);
    chk_eq("r0_count", CommitCount_out, 32'd2);

    // 4: jal forces r31 and ALU result over MemtoReg
    RegWrite_in  = 1'b1;
    Jal_in       = 1'b1;
    MemtoReg_in  = 1'b1;
    WriteReg_in  = 5'd5;
    ALUResult_in = 32'h00400008;
    ReadData_in  = 32'hCAFEF00D;
    ReadReg1_in  = 5'd31;
    ReadReg2_in  = 5'd5;
    #1;
    chk_eq("jal_waddr", 32'(WriteAddr_out), 32'd31);
    chk_eq("jal_wdata", WriteData_out, 32'h00400008);
    chk_eq("jal_bypass31", ReadData1_out, 32'h00400008);
    chk_eq("jal_r5_nobypass", ReadData2_out, 32'h0);
    step();
    idle();
    #1;
    chk_eq("jal_r31", ReadData1_out, 32'h00400008);
    chk_eq("jal_r5", ReadData2_out, 32'h0);
    chk_eq("jal_count", CommitCount_out, 32'd3);

    // 5: jr suppresses the write
    RegWrite_in  = 1'b1;
    JR_in        = 1'b1;
    WriteReg_in  = 5'd10;
    ALUResult_in = 32'h0000AAAA;
    ReadReg1_in  = 5'd10;
    #1;
    chk_eq("jr_we", 32'(WriteEn_out), 32'd0);
    chk_eq("jr_nobypass", ReadData1_out, 32'h0);
    step();
    idle();
    #1;
    chk_eq("jr_r10", ReadData1_out, 32'h0);
    chk_eq("jr_count", CommitCount_out, 32'd3);

    // Both ports bypass the same register
    RegWrite_in  = 1'b1;
    WriteReg_in  = 5'd12;
    ALUResult_in = 32'h00000077;
    ReadReg1_in  = 5'd12;
    ReadReg2_in  = 5'd12;
    #1;
    chk_eq("dual_bypass1", ReadData1_out, 32'h77);
    chk_eq("dual_bypass2", ReadData2_out, 32'h77);
    step();
    // Read of r12 while r13 is written returns stored value
    WriteReg_in  = 5'd13;
    ALUResult_in = 32'h00000099;
    ReadReg2_in  = 5'd13;
    #1;
    chk_eq("other_stored", ReadData1_out, 32'h77);
    chk_eq("other_bypass", ReadData2_out, 32'h99);
    step();
    idle();
    #1;
    chk_eq("r13_stored", ReadData2_out, 32'h99);
    chk_eq("pre_rst_count", CommitCount_out, 32'd5);

    // 6: write colliding with reset is dropped
    Rst          = 1'b1;
    RegWrite_in  = 1'b1;
    WriteReg_in  = 5'd12;
    ALUResult_in = 32'h00000055;
    #1;
    chk_eq("rstcol_we", 32'(WriteEn_out), 32'd0);
    chk_eq("rstcol_nobypass", ReadData1_out, 32'h77);
    step();
    Rst = 1'b0;
    idle();
    #1;
    chk_eq("rstcol_r12", ReadData1_out, 32'h0);
    chk_eq("rstcol_r13", ReadData2_out, 32'h0);
    chk_eq("rstcol_count", CommitCount_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
